// File: rtl/udma_eth_pkg.sv
// rtl/udma_eth_pkg.sv - shared types and constants for the Ethernet RX packer
//
// Holds the packer FSM state encoding and the uDMA datasize codes.
// datasize_enc() maps a word width in bits to its uDMA datasize code.
package udma_eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    localparam logic [1:0] DSIZE_8  = 2'b00;
    localparam logic [1:0] DSIZE_16 = 2'b01;
    localparam logic [1:0] DSIZE_32 = 2'b10;

    function automatic logic [1:0] datasize_enc(input int dw);
        case (dw)
            8:       return DSIZE_8;
            16:      return DSIZE_16;
            default: return DSIZE_32;
        endcase
    endfunction

endpackage

// File: rtl/udma_eth_rr_sel.sv
// rtl/udma_eth_rr_sel.sv - round-robin channel selector
//
// Purely combinational. Returns the first enabled channel strictly after
// last_id, searching upward and wrapping from NCH-1 to 0. last_id itself is
// the final candidate, so a single enabled channel is always reselected.
//
// Ports:
//   mask     in   2**ETHID_WIDTH  enabled channels
//   last_id  in   ETHID_WIDTH     previously used channel
//   next_id  out  ETHID_WIDTH     channel for the next frame (last_id if mask==0)
module udma_eth_rr_sel #(
    parameter int ETHID_WIDTH = 2
) (
    input  logic [2**ETHID_WIDTH-1:0] mask,
    input  logic [ETHID_WIDTH-1:0]    last_id,
    output logic [ETHID_WIDTH-1:0]    next_id
);

    // Scan from the farthest candidate down to the nearest so the nearest
    // enabled channel after last_id is the one left standing.
    always_comb begin
        next_id = last_id;
        for (int i = 2**ETHID_WIDTH; i >= 1; i--) begin
            if (mask[last_id + ETHID_WIDTH'(i)]) begin
                next_id = last_id + ETHID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/udma_eth_rx_packer.sv
// rtl/udma_eth_rx_packer.sv - packs an AXIS byte stream into uDMA RX words
//
// Accepts Ethernet frame bytes, packs them little-endian into DATA_WIDTH
// words and hands them to a uDMA RX channel picked round-robin per frame.
// Frames arriving while disabled (or with no enabled channel) are dropped
// and counted.
//
// Ports:
//   sys_clk_i, rstn_i           clock, asynchronous active-low reset
//   cfg_en_i, cfg_clr_i         accept new frames, synchronous clear
//   cfg_ch_mask_i               enabled channels (sampled at frame start)
//   s_axis_t*                   byte stream in; tuser flags a bad frame on tlast
//   rx_*                        uDMA word out with sof/eof/last-bytes markers
//   frame_done_o, frame_err_o   one-cycle pulses after an accepted frame end
//   frame_len_o                 byte count of the last completed frame
//   drop_cnt_o                  number of dropped frames (saturating)
module udma_eth_rx_packer
    import udma_eth_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ETHID_WIDTH = 2,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                      sys_clk_i,
    input  logic                      rstn_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    input  logic [2**ETHID_WIDTH-1:0] cfg_ch_mask_i,
    input  logic [7:0]                s_axis_tdata_i,
    input  logic                      s_axis_tvalid_i,
    output logic                      s_axis_tready_o,
    input  logic                      s_axis_tlast_i,
    input  logic                      s_axis_tuser_i,
    output logic [ETHID_WIDTH-1:0]    rx_id_o,
    output logic [DATA_WIDTH-1:0]     rx_data_o,
    output logic [1:0]                rx_datasize_o,
    output logic                      rx_valid_o,
    output logic                      rx_sof_o,
    output logic                      rx_eof_o,
    output logic [1:0]                rx_last_bytes_o,
    input  logic                      rx_ready_i,
    output logic                      frame_done_o,
    output logic                      frame_err_o,
    output logic [LEN_WIDTH-1:0]      frame_len_o,
    output logic [LEN_WIDTH-1:0]      drop_cnt_o
);

    localparam int                     BPW      = DATA_WIDTH / 8;
    localparam int                     NCH      = 2**ETHID_WIDTH;
    localparam logic [1:0]             IDX_LAST = 2'(BPW - 1);
    localparam logic [LEN_WIDTH-1:0]   LEN_MAX  = '1;
    localparam logic [ETHID_WIDTH-1:0] ID_INIT  = ETHID_WIDTH'(NCH - 1);

    rx_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]   acc_q, word_d, rx_data_q;
    logic [1:0]              idx_q, rx_last_bytes_q;
    logic [ETHID_WIDTH-1:0]  last_id_q, next_id, rx_id_q;
    logic [LEN_WIDTH-1:0]    len_cnt_q, len_d, frame_len_q, drop_cnt_q;
    logic                    rx_valid_q, rx_sof_q, rx_eof_q;
    logic                    sof_pend_q, sof_d, drop_cnt_en_q;
    logic                    frame_done_q, frame_err_q;
    logic                    tready, beat, start_frame, start_run, data_beat, word_done;

    udma_eth_rr_sel #(.ETHID_WIDTH(ETHID_WIDTH)) u_rr_sel (
        .mask    (cfg_ch_mask_i),
        .last_id (last_id_q),
        .next_id (next_id)
    );

    // Next-state and datapath decode.
    always_comb begin
        tready      = (state_q == ST_DROP) || !rx_valid_q || rx_ready_i;
        beat        = s_axis_tvalid_i && tready;
        start_frame = beat && (state_q == ST_IDLE);
        start_run   = start_frame && cfg_en_i && (cfg_ch_mask_i != '0);
        // The frame's first byte is packed in the same cycle RUN is entered.
        data_beat   = beat && ((state_q == ST_RUN) || start_run);
        word_done   = data_beat && ((idx_q == IDX_LAST) || s_axis_tlast_i);
        // The accumulator is zeroed after every word, so OR-ing in the new
        // byte leaves unused upper bytes of a short eof word at zero.
        word_d      = acc_q | (DATA_WIDTH'(s_axis_tdata_i) << {idx_q, 3'b000});
        sof_d       = start_run || sof_pend_q;
        if (start_run) begin
            len_d = LEN_WIDTH'(1);
        end else if (len_cnt_q == LEN_MAX) begin
            len_d = len_cnt_q;
        end else begin
            len_d = len_cnt_q + LEN_WIDTH'(1);
        end

        state_d = state_q;
        if (cfg_clr_i) begin
            if (state_q == ST_RUN) begin
                state_d = ST_DROP;
            end
        end else begin
            case (state_q)
                ST_IDLE: if (beat && !s_axis_tlast_i) state_d = start_run ? ST_RUN : ST_DROP;
                ST_RUN,
                ST_DROP: if (beat && s_axis_tlast_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q           <= '0;
            idx_q           <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_sof_q        <= 1'b0;
            rx_eof_q        <= 1'b0;
            rx_last_bytes_q <= '0;
            rx_id_q         <= '0;
            last_id_q       <= ID_INIT;
            sof_pend_q      <= 1'b0;
            len_cnt_q       <= '0;
            frame_len_q     <= '0;
            frame_done_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            drop_cnt_q      <= '0;
            drop_cnt_en_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (cfg_clr_i) begin
                // A frame already in flight is dropped but never counted.
                rx_valid_q    <= 1'b0;
                acc_q         <= '0;
                idx_q         <= '0;
                drop_cnt_q    <= '0;
                last_id_q     <= ID_INIT;
                drop_cnt_en_q <= 1'b0;
            end else begin
                if (rx_valid_q && rx_ready_i) begin
                    rx_valid_q <= 1'b0;
                end
                if (start_run) begin
                    rx_id_q   <= next_id;
                    last_id_q <= next_id;
                end
                if (start_frame && !start_run) begin
                    drop_cnt_en_q <= 1'b1;
                end
                if (data_beat) begin
                    len_cnt_q <= len_d;
                    if (word_done) begin
                        rx_data_q       <= word_d;
                        rx_valid_q      <= 1'b1;
                        rx_sof_q        <= sof_d;
                        rx_eof_q        <= s_axis_tlast_i;
                        rx_last_bytes_q <= s_axis_tlast_i ? idx_q : 2'd0;
                        acc_q           <= '0;
                        idx_q           <= '0;
                        sof_pend_q      <= 1'b0;
                    end else begin
                        acc_q      <= word_d;
                        idx_q      <= idx_q + 2'd1;
                        sof_pend_q <= sof_d;
                    end
                    if (s_axis_tlast_i) begin
                        frame_done_q <= 1'b1;
                        frame_err_q  <= s_axis_tuser_i;
                        frame_len_q  <= len_d;
                    end
                end
                // Single-byte dropped frames end in IDLE, hence the second term.
                if (beat && s_axis_tlast_i &&
                    (((state_q == ST_DROP) && drop_cnt_en_q) || (start_frame && !start_run)) &&
                    (drop_cnt_q != LEN_MAX)) begin
                    drop_cnt_q <= drop_cnt_q + LEN_WIDTH'(1);
                end
            end
        end
    end

    assign s_axis_tready_o = tready;
    assign rx_id_o         = rx_id_q;
    assign rx_data_o       = rx_data_q;
    assign rx_datasize_o   = datasize_enc(DATA_WIDTH);
    assign rx_valid_o      = rx_valid_q;
    assign rx_sof_o        = rx_sof_q;
    assign rx_eof_o        = rx_eof_q;
    assign rx_last_bytes_o = rx_last_bytes_q;
    assign frame_done_o    = frame_done_q;
    assign frame_err_o     = frame_err_q;
    assign frame_len_o     = frame_len_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_udma_eth_rx_packer.sv
// tb/tb_udma_eth_rx_packer.sv - directed self-checking bench for udma_eth_rx_packer
module tb_udma_eth_rx_packer;

    typedef struct packed {
        logic [1:0]  id;
        logic        sof;
        logic        eof;
        logic [1:0]  lb;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, cfg_en, cfg_clr;
    logic [3:0] cfg_mask;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, rx_ready;

    logic        tready32, valid32, sof32, eof32, done32, err32;
    logic [1:0]  id32, dsize32, lb32;
    logic [31:0] data32;
    logic [15:0] len32, drop32;

    logic        tready8, valid8, sof8, eof8, done8, err8;
    logic [1:0]  id8, dsize8, lb8;
    logic [7:0]  data8;
    logic [15:0] len8, drop8;

    udma_eth_rx_packer #(.DATA_WIDTH(32), .ETHID_WIDTH(2), .LEN_WIDTH(16)) u_dut (
        .sys_clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
        .cfg_ch_mask_i(cfg_mask), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
        .s_axis_tready_o(tready32), .s_axis_tlast_i(tlast), .s_axis_tuser_i(tuser),
        .rx_id_o(id32), .rx_data_o(data32), .rx_datasize_o(dsize32), .rx_valid_o(valid32),
        .rx_sof_o(sof32), .rx_eof_o(eof32), .rx_last_bytes_o(lb32), .rx_ready_i(rx_ready),
        .frame_done_o(done32), .frame_err_o(err32), .frame_len_o(len32), .drop_cnt_o(drop32)
    );

    udma_eth_rx_packer #(.DATA_WIDTH(8), .ETHID_WIDTH(2), .LEN_WIDTH(16)) u_dut8 (
        .sys_clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
        .cfg_ch_mask_i(cfg_mask), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
        .s_axis_tready_o(tready8), .s_axis_tlast_i(tlast), .s_axis_tuser_i(tuser),
        .rx_id_o(id8), .rx_data_o(data8), .rx_datasize_o(dsize8), .rx_valid_o(valid8),
        .rx_sof_o(sof8), .rx_eof_o(eof8), .rx_last_bytes_o(lb8), .rx_ready_i(rx_ready),
        .frame_done_o(done8), .frame_err_o(err8), .frame_len_o(len8), .drop_cnt_o(drop8)
    );

    int    vec_cnt = 0;
    int    err_cnt = 0;
    word_t q32[$], q8[$];
    int    len32_q[$], len8_q[$];
    bit    err32_q[$], err8_q[$];
    int    valid_seen32 = 0;
    int    lone_err = 0;

    // Capture every word the sink takes and every frame-done report.
    always @(negedge clk) begin
        if (valid32) valid_seen32++;
        if (valid32 && rx_ready) q32.push_back(word_t'{id32, sof32, eof32, lb32, data32});
        if (valid8 && rx_ready) q8.push_back(word_t'{id8, sof8, eof8, lb8, 32'(data8)});
        if (done32) begin len32_q.push_back(int'(len32)); err32_q.push_back(err32); end
        if (done8) begin len8_q.push_back(int'(len8)); err8_q.push_back(err8); end
        if ((err32 && !done32) || (err8 && !done8)) lone_err++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input bit narrow, input int idx, input word_t exp);
        logic [63:0] got;
        got = 64'hFFFF_FFFF_FFFF_FFFF;
        if (!narrow && idx < q32.size()) got = 64'(q32[idx]);
        if (narrow && idx < q8.size()) got = 64'(q8[idx]);
        check_val(tag, got, 64'(exp));
    endtask

    task automatic clear_logs();
        q32.delete(); q8.delete();
        len32_q.delete(); len8_q.delete(); err32_q.delete(); err8_q.delete();
        valid_seen32 = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic user, input logic clr);
        int n;
        n = 0;
        tdata = d; tlast = last; tuser = user; tvalid = 1'b1; cfg_clr = clr;
        @(negedge clk);
        while (!tready32 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check_val("tready_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; cfg_clr = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, input logic user);
        for (int i = 0; i < n; i++) send_byte(8'(base + 8'(i)), i == n - 1, user && (i == n - 1), 1'b0);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; cfg_clr = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_logs();
    endtask

    initial begin
        rstn = 1'b1; cfg_en = 1'b1; cfg_clr = 1'b0; cfg_mask = 4'b1111;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; rx_ready = 1'b1;
        #1 rstn = 1'b0;
        @(negedge clk);
        check_val("rst_tready", tready32, 1);
        check_val("rst_valid", valid32, 0);
        check_val("rst_dsize32", dsize32, 2'b10);
        check_val("rst_dsize8", dsize8, 2'b00);
        check_val("rst_outs", {id32, sof32, eof32, lb32, done32, err32}, 0);
        check_val("rst_len_drop", {len32, drop32}, 0);
        do_reset();

        // 6-byte frame, two words
        send_frame(6, 8'h01, 1'b0);
        drain();
        check_val("f6_words", q32.size(), 2);
        check_word("f6_w0", 1'b0, 0, word_t'{2'd0, 1'b1, 1'b0, 2'd0, 32'h04030201});
        check_word("f6_w1", 1'b0, 1, word_t'{2'd0, 1'b0, 1'b1, 2'd1, 32'h00000605});
        check_val("f6_done", len32_q.size(), 1);
        check_val("f6_len", len32, 16'd6);
        check_val("f6_err", (err32_q.size() > 0) ? err32_q[0] : 1'b1, 0);

        // partial frame discarded by reset, then round robin over mask 1010
        send_byte(8'hEE, 1'b0, 1'b0, 1'b0);
        send_byte(8'hEF, 1'b0, 1'b0, 1'b0);
        do_reset();
        cfg_mask = 4'b1010;
        send_frame(4, 8'h20, 1'b0);
        send_frame(4, 8'h30, 1'b0);
        send_frame(4, 8'h40, 1'b0);
        drain();
        check_val("rr_words", q32.size(), 3);
        check_word("rr_f0", 1'b0, 0, word_t'{2'd1, 1'b1, 1'b1, 2'd3, 32'h23222120});
        check_word("rr_f1", 1'b0, 1, word_t'{2'd3, 1'b1, 1'b1, 2'd3, 32'h33323130});
        check_word("rr_f2", 1'b0, 2, word_t'{2'd1, 1'b1, 1'b1, 2'd3, 32'h43424140});

        // sink backpressure for 10 cycles mid-frame
        do_reset();
        cfg_mask = 4'b1111;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + 8'(i)), 1'b0, 1'b0, 1'b0);
        rx_ready = 1'b0;
        fork
            begin
                for (int i = 6; i < 12; i++) send_byte(8'(8'h10 + 8'(i)), i == 11, 1'b0, 1'b0);
            end
            begin
                int n;
                int bad;
                n = 0; bad = 0;
                @(negedge clk);
                while (!valid32 && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                check_val("stall_valid", valid32, 1);
                for (int k = 0; k < 10; k++) begin
                    if (tready32 !== 1'b0 || data32 !== 32'h17161514 || valid32 !== 1'b1) bad++;
                    @(negedge clk);
                end
                check_val("stall_hold", bad, 0);
                @(posedge clk); #1;
                rx_ready = 1'b1;
            end
        join
        drain();
        check_val("stall_words", q32.size(), 3);
        check_word("stall_w0", 1'b0, 0, word_t'{2'd0, 1'b1, 1'b0, 2'd0, 32'h13121110});
        check_word("stall_w1", 1'b0, 1, word_t'{2'd0, 1'b0, 1'b0, 2'd0, 32'h17161514});
        check_word("stall_w2", 1'b0, 2, word_t'{2'd0, 1'b0, 1'b1, 2'd3, 32'h1B1A1918});
        check_val("stall_len", len32, 16'd12);

        // disabled: two 64-byte frames dropped, then cleared
        do_reset();
        cfg_en = 1'b0;
        send_frame(64, 8'h80, 1'b0);
        send_frame(64, 8'h00, 1'b0);
        drain();
        check_val("drop_no_valid", valid_seen32, 0);
        check_val("drop_no_done", len32_q.size(), 0);
        check_val("drop_cnt2", drop32, 16'd2);
        cfg_clr = 1'b1;
        @(posedge clk); #1;
        cfg_clr = 1'b0;
        check_val("drop_clr", drop32, 16'd0);
        cfg_en = 1'b1;

        // clear at byte 3 of a 10-byte frame
        do_reset();
        cfg_mask = 4'b0111;
        send_frame(4, 8'h50, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + 8'(i)), 1'b0, 1'b0, 1'b0);
        send_byte(8'h63, 1'b0, 1'b0, 1'b1);
        for (int i = 4; i < 10; i++) send_byte(8'(8'h60 + 8'(i)), i == 9, 1'b0, 1'b0);
        drain();
        check_val("clr_words", q32.size(), 1);
        check_val("clr_done", len32_q.size(), 1);
        check_val("clr_drop", drop32, 16'd0);
        send_frame(4, 8'h70, 1'b0);
        drain();
        check_word("clr_first", 1'b0, 0, word_t'{2'd0, 1'b1, 1'b1, 2'd3, 32'h53525150});
        check_word("clr_next", 1'b0, 1, word_t'{2'd0, 1'b1, 1'b1, 2'd3, 32'h73727170});

        // 8-bit words, bad-frame flag on tlast
        do_reset();
        cfg_mask = 4'b0001;
        send_frame(3, 8'hC1, 1'b1);
        drain();
        check_val("w8_words", q8.size(), 3);
        check_word("w8_w0", 1'b1, 0, word_t'{2'd0, 1'b1, 1'b0, 2'd0, 32'h000000C1});
        check_word("w8_w1", 1'b1, 1, word_t'{2'd0, 1'b0, 1'b0, 2'd0, 32'h000000C2});
        check_word("w8_w2", 1'b1, 2, word_t'{2'd0, 1'b0, 1'b1, 2'd0, 32'h000000C3});
        check_val("w8_done", len8_q.size(), 1);
        check_val("w8_err", (err8_q.size() > 0) ? err8_q[0] : 1'b0, 1);
        check_val("w8_len", (len8_q.size() > 0) ? len8_q[0] : 0, 3);
        check_val("err_without_done", lone_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/udma_eth_rx_packer.md
UDMA_ETH_RX_PACKER -- requirements
Module: udma_eth_rx_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning uDMA word width; legal values 8, 16, 32; BPW = DATA_WIDTH/8.
REQ-002 SHALL have parameter ETHID_WIDTH, default 2, meaning channel-ID width; NCH = 2**ETHID_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning frame-length and drop-counter width.
REQ-004 SHALL have ports: sys_clk_i  in  1  sole clock; rstn_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: cfg_en_i  in  1  accept new frames; cfg_clr_i  in  1  synchronous clear; cfg_ch_mask_i  in  NCH  enabled channels.
REQ-006 SHALL have AXIS byte input ports: s_axis_tdata_i  in  8; s_axis_tvalid_i  in  1; s_axis_tready_o  out  1; s_axis_tlast_i  in  1; s_axis_tuser_i  in  1  bad-frame flag, meaningful on the tlast beat only.
REQ-007 SHALL have uDMA output ports: rx_id_o  out  ETHID_WIDTH; rx_data_o  out  DATA_WIDTH; rx_datasize_o  out  2; rx_valid_o  out  1; rx_sof_o  out  1; rx_eof_o  out  1; rx_last_bytes_o  out  2  valid bytes minus one in the eof word; rx_ready_i  in  1.
REQ-008 SHALL have status ports: frame_done_o  out  1  pulse; frame_err_o  out  1  pulse; frame_len_o  out  LEN_WIDTH; drop_cnt_o  out  LEN_WIDTH.

Function
REQ-009 SHALL pack accepted bytes little-endian: the first byte of each word goes to bits [7:0].
REQ-010 SHALL complete a word when BPW bytes are accumulated or on the tlast byte. The completed word SHALL appear on rx_data_o with rx_valid_o=1 one cycle after the completing byte is accepted.
REQ-011 SHALL drive rx_datasize_o constantly: 00 for DATA_WIDTH 8, 01 for 16, 10 for 32.
REQ-012 SHALL zero unused upper bytes of a partial eof word and set rx_last_bytes_o to the byte count minus 1; rx_last_bytes_o SHALL be 0 on non-eof words.
REQ-013 SHALL hold rx_data_o, rx_id_o, rx_sof_o, rx_eof_o and rx_last_bytes_o stable while rx_valid_o=1 and rx_ready_i=0.
REQ-014 SHALL drive s_axis_tready_o = (!rx_valid_o || rx_ready_i) in states IDLE and RUN, and 1 in DROP. Back-to-back words SHALL stream at one byte per cycle.
REQ-015 SHALL implement FSM IDLE/RUN/DROP. IDLE -> RUN on an accepted byte when cfg_en_i=1 and cfg_ch_mask_i!=0. IDLE -> DROP on an accepted byte otherwise. RUN/DROP -> IDLE on an accepted tlast byte.
REQ-016 SHALL choose the frame channel at IDLE -> RUN as the first enabled channel after the previously used one, in ascending order with wrap from NCH-1 to 0. rx_id_o SHALL stay constant for the whole frame.
REQ-017 SHALL assert rx_sof_o on the first word of a frame and rx_eof_o on the last word; a single-word frame SHALL assert both.
REQ-018 SHALL sample cfg_en_i and cfg_ch_mask_i only at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-019 SHALL count accepted bytes per frame, saturating at 2**LEN_WIDTH-1.
REQ-020 SHALL handle the accepted tlast byte in RUN as follows, one cycle later: frame_done_o=1 for one cycle; frame_len_o = byte count, held until the next frame_done_o; frame_err_o = s_axis_tuser_i for one cycle.
REQ-021 SHALL emit no output words for a DROP frame and SHALL increment drop_cnt_o, saturating, when that frame's tlast byte is accepted.
REQ-022 SHALL respond to cfg_clr_i=1 as follows: clear rx_valid_o, the accumulator, drop_cnt_o and the round-robin pointer (next channel = lowest enabled); go from RUN to DROP, without incrementing drop_cnt_o for that frame; go from DROP to DROP; go from IDLE to IDLE. cfg_clr_i SHALL have priority over every other event in the same cycle.

Reset
REQ-023 SHALL, while rstn_i=0, asynchronously force: state IDLE; all outputs 0 except s_axis_tready_o=1 and rx_datasize_o at its constant; round-robin pointer to NCH-1.
REQ-024 SHALL discard any partially received frame on reset. After reset the next byte SHALL be treated as the start of a frame.

Structure
REQ-025 SHALL place the state enum and the datasize encoding constants in shared package udma_eth_pkg.
REQ-026 SHALL implement channel selection in sub-module udma_eth_rr_sel: inputs mask and last-ID, output next-ID; purely combinational.

Verification
REQ-027 SHALL cover: DATA_WIDTH=32, 6-byte frame 01..06, rx_ready_i=1 -> words 0x04030201 (sof) and 0x00000605 (eof, rx_last_bytes_o=1); frame_len_o=6.
REQ-028 SHALL cover: mask 4'b1010, three frames -> rx_id_o sequence 1, 3, 1.
REQ-029 SHALL cover: rx_ready_i=0 for 10 cycles mid-frame -> s_axis_tready_o=0, rx_data_o stable, no byte lost.
REQ-030 SHALL cover: cfg_en_i=0, two 64-byte frames -> no rx_valid_o, drop_cnt_o=2; then cfg_clr_i -> drop_cnt_o=0.
REQ-031 SHALL cover: cfg_clr_i at byte 3 of a 10-byte frame -> remainder discarded, drop_cnt_o=0, next frame starts with sof on the lowest enabled channel.
REQ-032 SHALL cover: tuser=1 on tlast with DATA_WIDTH=8 -> frame_err_o=1 coincident with frame_done_o.
